// File: rtl/note_event_sequencer.sv
// note_event_sequencer: records time-stamped key vectors into a buffer and replays them against the microsecond timer.
// Optional feature macro: LOOP_PLAYBACK_EN (restart playback from the first entry when the buffer is exhausted).
module note_event_sequencer #(
  parameter int unsigned KEYS      = 8,
  parameter int unsigned TIME_BITS = 29,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned MAX_TIME  = 300000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEYS-1:0]      keys,
  input  logic [TIME_BITS-1:0] microSecondCounter,
  input  logic                 record_start,
  input  logic                 play_start,
  input  logic                 stop,
  output logic                 timer_enable,
  output logic                 timer_clear,
  output logic [KEYS-1:0]      play_keys,
  output logic [ADDR_BITS:0]   event_count,
  output logic                 overflow,
  output logic [1:0]           mode
);

  localparam int unsigned ENTRY_W = TIME_BITS + KEYS;
  localparam logic [ADDR_BITS:0]   DEPTH_C    = (ADDR_BITS+1)'(DEPTH);
  localparam logic [TIME_BITS-1:0] MAX_TIME_C = TIME_BITS'(MAX_TIME);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_RECORD = 2'd2,
    S_PLAY   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_data;
  logic [ENTRY_W-1:0] wr_data;
  logic               wr_en;

  logic [ADDR_BITS:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_BITS:0] count_nxt;
  logic               head_valid, head_valid_nxt;
  logic [KEYS-1:0]    keys_prev, keys_prev_nxt;
  logic [KEYS-1:0]    play_keys_nxt;
  logic               ovf_nxt;
  logic               tgt_play, tgt_play_nxt;

  logic has_space, rec_exit, head_due, play_done;

  assign has_space = event_count < DEPTH_C;
  assign rec_exit  = stop || (microSecondCounter >= MAX_TIME_C);
  assign head_due  = head_valid && (microSecondCounter >= rd_data[ENTRY_W-1:KEYS]);
  assign play_done = rd_ptr == event_count;
  assign mode      = state;

  // Next-state and datapath update decisions
  always_comb begin
    state_next     = state;
    tgt_play_nxt   = tgt_play;
    count_nxt      = event_count;
    ovf_nxt        = overflow;
    keys_prev_nxt  = keys_prev;
    rd_ptr_nxt     = rd_ptr;
    head_valid_nxt = 1'b0;
    play_keys_nxt  = play_keys;
    wr_en          = 1'b0;
    wr_data        = {microSecondCounter, keys};
    unique case (state)
      S_IDLE: begin
        if (!stop) begin
          if (record_start) begin
            state_next    = S_CLEAR;
            tgt_play_nxt  = 1'b0;
            count_nxt     = '0;
            ovf_nxt       = 1'b0;
            keys_prev_nxt = '0;
          end else if (play_start && (event_count != '0)) begin
            state_next    = S_CLEAR;
            tgt_play_nxt  = 1'b1;
            rd_ptr_nxt    = '0;
            play_keys_nxt = '0;
          end
        end
      end
      S_CLEAR: begin
        if (stop) state_next = S_IDLE;
        else      state_next = tgt_play ? S_PLAY : S_RECORD;
      end
      S_RECORD: begin
        keys_prev_nxt = keys;
        // Exit closes any held notes; a key change in this cycle is superseded
        if (rec_exit) begin
          state_next = S_IDLE;
          if ((keys_prev != '0) && has_space) begin
            wr_en     = 1'b1;
            wr_data   = {microSecondCounter, KEYS'(0)};
            count_nxt = event_count + (ADDR_BITS+1)'(1);
          end
        end else if (keys != keys_prev) begin
          if (has_space) begin
            wr_en     = 1'b1;
            count_nxt = event_count + (ADDR_BITS+1)'(1);
          end else begin
            ovf_nxt = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_next    = S_IDLE;
          play_keys_nxt = '0;
        end else if (play_done) begin
          play_keys_nxt = '0;
`ifdef LOOP_PLAYBACK_EN
          state_next    = S_CLEAR;
          rd_ptr_nxt    = '0;
`else
          state_next    = S_IDLE;
`endif
        end else if (head_due) begin
          play_keys_nxt = rd_data[KEYS-1:0];
          rd_ptr_nxt    = rd_ptr + (ADDR_BITS+1)'(1);
        end else begin
          head_valid_nxt = 1'b1;
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      tgt_play     <= 1'b0;
      event_count  <= '0;
      overflow     <= 1'b0;
      keys_prev    <= '0;
      rd_ptr       <= '0;
      head_valid   <= 1'b0;
      play_keys    <= '0;
      timer_enable <= 1'b0;
      timer_clear  <= 1'b0;
    end else begin
      state        <= state_next;
      tgt_play     <= tgt_play_nxt;
      event_count  <= count_nxt;
      overflow     <= ovf_nxt;
      keys_prev    <= keys_prev_nxt;
      rd_ptr       <= rd_ptr_nxt;
      head_valid   <= head_valid_nxt;
      play_keys    <= play_keys_nxt;
      timer_enable <= (state_next == S_RECORD) || (state_next == S_PLAY);
      timer_clear  <= state_next == S_CLEAR;
    end
  end

  // Event buffer: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[event_count[ADDR_BITS-1:0]] <= wr_data;
    rd_data <= mem[rd_ptr[ADDR_BITS-1:0]];
  end

endmodule
